// File: rtl/light_sequencer.sv
// light_sequencer: autonomous command-side timing sequencer for the traffic-light control unit.
// It walks red -> green -> yellow -> red, issuing a 2-bit light-select code and waiting for the
// matching one-hot acknowledgement. Any missing or inconsistent acknowledgement lands the block
// in a sticky fault state until reset.
// Build option: define SEQ_PED_EN to compile in the pedestrian latch, PED state and btn pulse.
// Without it, btn and ped_pending are held at 0 and green always runs its full dwell.

module light_sequencer #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned RED_CYCLES    = 20,
  parameter int unsigned GREEN_CYCLES  = 30,
  parameter int unsigned YELLOW_CYCLES = 5,
  parameter int unsigned MIN_GREEN     = 10,
  parameter int unsigned ACK_TIMEOUT   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       ped_req,
  input  logic [2:0] cw_traffic_lights,
  output logic [1:0] sw_traffic_lights,
  output logic       btn,
  output logic [1:0] phase,
  output logic       ped_pending,
  output logic       fault
);

  typedef enum logic [2:0] {StBoot, StDwell, StReq, StPed, StFault} state_e;

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeRed    = 2'b01;
  localparam logic [1:0] CodeGreen  = 2'b10;
  localparam logic [1:0] CodeYellow = 2'b11;

  // Last count value of each dwell / wait window; the transition fires when that value is held.
  localparam logic [CNT_W-1:0] RedLast    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AckLast    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

`ifdef SEQ_PED_EN
  localparam logic [CNT_W-1:0] MinGreen   = CNT_W'(MIN_GREEN);
`else
  // Pedestrian inputs have no effect in this build.
  logic unused_ped;
  assign unused_ped = ped_req | (MIN_GREEN != 0);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       sw_q, sw_d;
  logic             btn_q, btn_d;
  logic [1:0]       phase_q, phase_d;
  logic             pend_q, pend_d;
  logic             fault_q, fault_d;

  function automatic logic [2:0] code_onehot(input logic [1:0] code);
    logic [2:0] oh;
    case (code)
      CodeRed:    oh = 3'b100;
      CodeGreen:  oh = 3'b010;
      CodeYellow: oh = 3'b001;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] code_next(input logic [1:0] code);
    logic [1:0] nxt;
    case (code)
      CodeRed:    nxt = CodeGreen;
      CodeGreen:  nxt = CodeYellow;
      default:    nxt = CodeRed;
    endcase
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] dwell_last(input logic [1:0] code);
    logic [CNT_W-1:0] last;
    case (code)
      CodeGreen:  last = GreenLast;
      CodeYellow: last = YellowLast;
      default:    last = RedLast;
    endcase
    return last;
  endfunction

  // Next-state and next-output decode for the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sw_d     = CodeNone;
    btn_d    = 1'b0;
    phase_d  = phase_q;
    fault_d  = fault_q;

`ifdef SEQ_PED_EN
    pend_d = pend_q;
    if (ped_req && (state_q != StFault)) begin
      pend_d = 1'b1;
    end
`else
    pend_d = 1'b0;
`endif

    unique case (state_q)
      StBoot: begin
        if (cw_traffic_lights == 3'b100) begin
          state_d = StDwell;
          phase_d = CodeRed;
          cnt_d   = '0;
        end else if (cnt_q == AckLast) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StDwell: begin
        // The control unit must keep showing the acknowledged phase for the whole dwell.
        if (cw_traffic_lights != code_onehot(phase_q)) begin
          state_d = StFault;
          fault_d = 1'b1;
`ifdef SEQ_PED_EN
        end else if ((phase_q == CodeGreen) && pend_q && (cnt_q >= MinGreen)) begin
          // Pedestrian service wins over a green expiry on the same edge.
          state_d = StPed;
          btn_d   = 1'b1;
          cnt_d   = '0;
          pend_d  = 1'b0;
`endif
        end else if (enable) begin
          if (cnt_q == dwell_last(phase_q)) begin
            state_d  = StReq;
            target_d = code_next(phase_q);
            sw_d     = code_next(phase_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      StReq: begin
        sw_d = target_q;
        // An acknowledgement arriving on the timeout edge still counts.
        if (cw_traffic_lights == code_onehot(target_q)) begin
          state_d = StDwell;
          phase_d = target_q;
          sw_d    = CodeNone;
          cnt_d   = '0;
`ifdef SEQ_PED_EN
          if (target_q == CodeYellow) begin
            pend_d = 1'b0;
          end
`endif
        end else if (cnt_q == AckLast) begin
          state_d = StFault;
          fault_d = 1'b1;
          sw_d    = CodeNone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StPed: begin
        state_d  = StReq;
        target_d = CodeYellow;
        sw_d     = CodeYellow;
        cnt_d    = '0;
      end

      StFault: begin
        fault_d = 1'b1;
      end

      default: begin
        state_d = StFault;
        fault_d = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs; async reset returns everything to BOOT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StBoot;
      cnt_q    <= '0;
      target_q <= CodeNone;
      sw_q     <= CodeNone;
      btn_q    <= 1'b0;
      phase_q  <= CodeNone;
      pend_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sw_q     <= sw_d;
      btn_q    <= btn_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      fault_q  <= fault_d;
    end
  end

  assign sw_traffic_lights = sw_q;
  assign btn               = btn_q;
  assign phase             = phase_q;
  assign ped_pending       = pend_q;
  assign fault             = fault_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Testbench for light_sequencer with a registered control-unit model. Expected sequencer events
// (command issued, phase acknowledged, button pulse, fault) are queued with their cycle distance
// from the previous event and compared as the DUT produces them.

module tb_light_sequencer;

  localparam int unsigned RedC   = 4;
  localparam int unsigned GreenC = 6;
  localparam int unsigned YelC   = 2;
  localparam int unsigned MinG   = 2;
  localparam int unsigned AckT   = 4;

  localparam logic [1:0] KSw    = 2'd0;
  localparam logic [1:0] KPhase = 2'd1;
  localparam logic [1:0] KBtn   = 2'd2;
  localparam logic [1:0] KFault = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  val;
    logic [31:0] gap;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       ped_req;
  logic [2:0] cw;
  logic [1:0] sw;
  logic       btn;
  logic [1:0] phase;
  logic       ped_pending;
  logic       fault;

  logic [2:0] cu_q;
  logic       cu_stuck;
  logic       force_en;
  logic [2:0] force_val;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_evt = 0;
  evt_t exp_q[$];

  logic [1:0] prev_phase = 2'b00;
  logic [1:0] prev_sw    = 2'b00;
  logic       prev_btn   = 1'b0;
  logic       prev_fault = 1'b0;

  always #5 clk = ~clk;

  light_sequencer #(
    .CNT_W         (8),
    .RED_CYCLES    (RedC),
    .GREEN_CYCLES  (GreenC),
    .YELLOW_CYCLES (YelC),
    .MIN_GREEN     (MinG),
    .ACK_TIMEOUT   (AckT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .ped_req           (ped_req),
    .cw_traffic_lights (cw),
    .sw_traffic_lights (sw),
    .btn               (btn),
    .phase             (phase),
    .ped_pending       (ped_pending),
    .fault             (fault)
  );

  // Control unit: powers up showing red, follows the command one edge later, blanks on btn.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cu_q <= 3'b100;
    end else if (!cu_stuck) begin
      if (btn) begin
        cu_q <= 3'b000;
      end else begin
        case (sw)
          2'b01:   cu_q <= 3'b100;
          2'b10:   cu_q <= 3'b010;
          2'b11:   cu_q <= 3'b001;
          default: cu_q <= cu_q;
        endcase
      end
    end
  end

  assign cw = force_en ? force_val : cu_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: detects DUT events at the falling edge and scores them against the queue.
  always @(negedge clk) begin : monitor
    evt_t got;
    evt_t expv;
    logic have;
    have = 1'b0;
    got  = '0;
    if (reset_n) begin
      if (phase != prev_phase && phase != 2'b00) begin
        have = 1'b1; got.kind = KPhase; got.val = phase;
      end else if (btn && !prev_btn) begin
        have = 1'b1; got.kind = KBtn;
      end else if (sw != 2'b00 && prev_sw == 2'b00) begin
        have = 1'b1; got.kind = KSw; got.val = sw;
      end else if (fault && !prev_fault) begin
        have = 1'b1; got.kind = KFault;
      end
      if (have) begin
        got.gap  = 32'(cyc - last_evt);
        last_evt = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected got kind=%0d val=%0d gap=%0d, required none",
                   got.kind, got.val, got.gap);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            n_fail++;
            $display("FAIL event kind/val/gap got=%0d/%0d/%0d required=%0d/%0d/%0d",
                     got.kind, got.val, got.gap, expv.kind, expv.val, expv.gap);
          end
        end
      end
    end
    prev_phase = phase;
    prev_sw    = sw;
    prev_btn   = btn;
    prev_fault = fault;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] kind, input logic [1:0] val, input int gap);
    exp_q.push_back({kind, val, 32'(gap)});
  endtask

  // Wait (bounded) until at most n expected events remain outstanding.
  task automatic wait_q(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() > n && i < budget) begin
      tick(1);
      i++;
    end
    n_checks++;
    if (exp_q.size() > n) begin
      n_fail++;
      $display("FAIL %s_timeout outstanding=%0d required<=%0d", name, exp_q.size(), n);
    end
  endtask

  task automatic do_reset(input bit boot_ok);
    reset_n  = 1'b0;
    enable   = 1'b1;
    ped_req  = 1'b0;
    cu_stuck = 1'b0;
    if (boot_ok) force_en = 1'b0;
    exp_q.delete();
    tick(2);
    if (boot_ok) push(KPhase, 2'b01, 1);
    else         push(KFault, 2'b00, AckT);
    reset_n  = 1'b1;
    last_evt = cyc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({sw, btn, phase, ped_pending, fault} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required=0000000", {sw, btn, phase, ped_pending, fault});
    end
    do_reset(1'b1);
    wait_q(0, 5, "reset_boot");
    n_checks++;
    if ({sw, phase, fault} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_red_dwell sw/phase/fault got=%b required=00010", {sw, phase, fault});
    end
  endtask

  task automatic test_normal();
    do_reset(1'b1);
    push(KSw, 2'b10, RedC);    push(KPhase, 2'b10, 2);
    push(KSw, 2'b11, GreenC);  push(KPhase, 2'b11, 2);
    push(KSw, 2'b01, YelC);    push(KPhase, 2'b01, 2);
    push(KSw, 2'b10, RedC);
    wait_q(0, 60, "normal");
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_no_fault got=%b required=0", fault);
    end
  endtask

  task automatic test_ped();
    do_reset(1'b1);
    tick(1);
    ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0;
`ifdef SEQ_PED_EN
    n_checks++;
    if (ped_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL ped_latched got=%b required=1", ped_pending);
    end
    push(KSw, 2'b10, RedC);  push(KPhase, 2'b10, 2);
    push(KBtn, 2'b00, MinG + 1);
    push(KSw, 2'b11, 1);     push(KPhase, 2'b11, 2);
    wait_q(2, 30, "ped_btn");
    n_checks++;
    if ({cw, btn, ped_pending} !== 5'b00000) begin
      n_fail++;
      $display("FAIL ped_button_step cw/btn/pend got=%b required=00000", {cw, btn, ped_pending});
    end
    tick(1);
    n_checks++;
    if (cw !== 3'b001) begin
      n_fail++;
      $display("FAIL ped_yellow_ack cw got=%b required=001", cw);
    end
    wait_q(0, 10, "ped_yellow");
    n_checks++;
    if ({phase, ped_pending, fault} !== 4'b1100) begin
      n_fail++;
      $display("FAIL ped_end phase/pend/fault got=%b required=1100", {phase, ped_pending, fault});
    end
`else
    n_checks++;
    if ({ped_pending, btn} !== 2'b00) begin
      n_fail++;
      $display("FAIL ped_ignored pend/btn got=%b required=00", {ped_pending, btn});
    end
    push(KSw, 2'b10, RedC);    push(KPhase, 2'b10, 2);
    push(KSw, 2'b11, GreenC);  push(KPhase, 2'b11, 2);
    wait_q(0, 40, "ped_disabled");
    n_checks++;
    if ({ped_pending, fault} !== 2'b00) begin
      n_fail++;
      $display("FAIL ped_disabled_end pend/fault got=%b required=00", {ped_pending, fault});
    end
`endif
  endtask

  task automatic test_ack_timeout();
    do_reset(1'b1);
    cu_stuck = 1'b1;
    push(KSw, 2'b10, RedC);
    push(KFault, 2'b00, AckT);
    wait_q(0, 30, "ack_timeout");
    n_checks++;
    if ({sw, phase, fault} !== 5'b00011) begin
      n_fail++;
      $display("FAIL ack_timeout_state sw/phase/fault got=%b required=00011", {sw, phase, fault});
    end
    tick(3);
    n_checks++;
    if ({sw, btn, fault} !== 4'b0001) begin
      n_fail++;
      $display("FAIL fault_sticky sw/btn/fault got=%b required=0001", {sw, btn, fault});
    end
  endtask

  task automatic test_dwell_deviation();
    do_reset(1'b1);
    push(KSw, 2'b10, RedC);  push(KPhase, 2'b10, 2);
    push(KFault, 2'b00, 3);
    wait_q(1, 20, "deviation_green");
    tick(1);
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL deviation_pre got=%b required=0", fault);
    end
    force_en  = 1'b1;
    force_val = 3'b001;
    tick(1);
    n_checks++;
    if ({sw, fault} !== 3'b001) begin
      n_fail++;
      $display("FAIL deviation_fault sw/fault got=%b required=001", {sw, fault});
    end
    wait_q(0, 5, "deviation");
  endtask

  task automatic test_enable_hold();
    do_reset(1'b1);
    push(KSw, 2'b10, RedC);        push(KPhase, 2'b10, 2);
    push(KSw, 2'b11, GreenC + 5);  push(KPhase, 2'b11, 2);
    wait_q(2, 20, "hold_green");
    tick(1);
    enable = 1'b0;
    tick(5);
    enable = 1'b1;
    wait_q(0, 30, "enable_hold");
  endtask

  task automatic test_reset_mid_req();
    do_reset(1'b1);
    push(KSw, 2'b10, RedC);
    wait_q(0, 20, "mid_req");
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({sw, btn, phase, ped_pending, fault} !== 7'b0) begin
      n_fail++;
      $display("FAIL midreq_async_clear got=%b required=0000000",
               {sw, btn, phase, ped_pending, fault});
    end
    do_reset(1'b1);
    wait_q(0, 5, "mid_req_reboot");
    n_checks++;
    if ({sw, phase, fault} !== 5'b00010) begin
      n_fail++;
      $display("FAIL midreq_reboot sw/phase/fault got=%b required=00010", {sw, phase, fault});
    end
  endtask

  task automatic test_boot_timeout();
    force_en  = 1'b1;
    force_val = 3'b000;
    do_reset(1'b0);
    wait_q(0, 10, "boot_timeout");
    n_checks++;
    if ({sw, phase, fault} !== 5'b00001) begin
      n_fail++;
      $display("FAIL boot_timeout_state sw/phase/fault got=%b required=00001", {sw, phase, fault});
    end
    force_en = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    ped_req   = 1'b0;
    cu_stuck  = 1'b0;
    force_en  = 1'b0;
    force_val = 3'b000;
    test_reset();
    test_normal();
    test_ped();
    test_ack_timeout();
    test_dwell_deviation();
    test_enable_hold();
    test_reset_mid_req();
    test_boot_timeout();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
